// File: rtl/p_s_cp_insert.sv
// Parallel-to-serial converter with cyclic-prefix insertion.
// Captures one N-sample complex symbol in a single beat and streams
// N+CP serial samples: the last CP samples first, then all N in order.
module p_s_cp_insert #(
   parameter int WIDTH = 16,
   parameter int N     = 16,
   parameter int CP    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N*WIDTH-1:0]        din_real,
   input  logic [N*WIDTH-1:0]        din_imag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          dout_real,
   output logic [WIDTH-1:0]          dout_imag,
   output logic                      sof,
   output logic                      eof,
   output logic [$clog2(N+CP)-1:0]   idx
);

   localparam int IW = $clog2(N+CP);
   localparam int SW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N+CP-1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                      state, state_n;
   logic [IW-1:0]               idx_n;
   logic [N-1:0][WIDTH-1:0]     sym_re, sym_im;
   logic [SW-1:0]               sel;
   logic                        load, fire, last;

   // State, position counter and symbol buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         sym_re <= '0;
         sym_im <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         if (load) begin
            sym_re <= din_real;
            sym_im <= din_imag;
         end
      end
   end

   // Handshakes and next-state; a new symbol can be taken on the eof
   // transfer so back-to-back symbols stream without a bubble
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      out_valid = (state == SEND);
      last      = (idx == LAST);
      fire      = out_valid && out_ready;
      in_ready  = (state == IDLE) || (fire && last);
      load      = in_valid && in_ready;
      case (state)
         IDLE: begin
            if (load) begin
               state_n = SEND;
               idx_n   = '0;
            end
         end
         SEND: begin
            if (fire) begin
               if (last) begin
                  idx_n = '0;
                  if (!load) state_n = IDLE;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sample select: prefix positions read the tail of the symbol
   always_comb begin
      if (idx < IW'(CP)) sel = SW'(idx + IW'(N-CP));
      else               sel = SW'(idx - IW'(CP));
   end

   // Outputs are zero while idle; otherwise driven from registered state
   // only, so they stay stable through a downstream stall
   always_comb begin
      dout_real = '0;
      dout_imag = '0;
      if (state == SEND) begin
         dout_real = sym_re[sel];
         dout_imag = sym_im[sel];
      end
      sof = out_valid && (idx == '0);
      eof = out_valid && last;
   end

endmodule

// File: tb/tb_p_s_cp_insert.sv
// Scoreboard bench for p_s_cp_insert: every accepted symbol pushes its
// expected N+CP output beats; a monitor compares each presented beat.
module tb_p_s_cp_insert;

   localparam int W  = 16;
   localparam int N  = 16;
   localparam int CP = 4;
   localparam int IW = $clog2(N+CP);

   typedef struct {
      logic [W-1:0] re;
      logic [W-1:0] im;
      int           pos;
      bit           sof;
      bit           eof;
   } exp_t;

   logic              clk = 0;
   logic              rst = 1;
   logic              in_valid = 0;
   logic              in_ready;
   logic [N*W-1:0]    din_real = '0;
   logic [N*W-1:0]    din_imag = '0;
   logic              out_valid;
   logic              out_ready = 1;
   logic [W-1:0]      dout_real, dout_imag;
   logic              sof, eof;
   logic [IW-1:0]     idx;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   p_s_cp_insert #(.WIDTH(W), .N(N), .CP(CP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din_real(din_real), .din_imag(din_imag), .out_valid(out_valid),
      .out_ready(out_ready), .dout_real(dout_real), .dout_imag(dout_imag),
      .sof(sof), .eof(eof), .idx(idx)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endfunction

   // Reference: one symbol becomes its last CP samples, then all N samples
   function automatic void push_symbol(input logic [N*W-1:0] re, input logic [N*W-1:0] im);
      int j = 0;
      exp_t e;
      for (int k = N-CP; k < N; k++) begin
         e.re = re[k*W +: W]; e.im = im[k*W +: W];
         e.pos = j; e.sof = (j == 0); e.eof = 0;
         q.push_back(e); j++;
      end
      for (int k = 0; k < N; k++) begin
         e.re = re[k*W +: W]; e.im = im[k*W +: W];
         e.pos = j; e.sof = 0; e.eof = (k == N-1);
         q.push_back(e); j++;
      end
   endfunction

   // Monitor: compare presented beat, pop on transfer, push on acceptance
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         chk("out_valid", out_valid, q.size() != 0);
         chk("in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
         if (q.size() != 0) begin
            chk("dout_real", dout_real, q[0].re);
            chk("dout_imag", dout_imag, q[0].im);
            chk("idx", idx, q[0].pos);
            chk("sof", sof, q[0].sof);
            chk("eof", eof, q[0].eof);
            if (out_ready) void'(q.pop_front());
         end else begin
            chk("idle_dout", {dout_real, dout_imag}, 32'h0);
            chk("idle_flags", {sof, eof}, 2'b00);
         end
         if (in_valid && in_ready) push_symbol(din_real, din_imag);
      end
   end

   task automatic send(input logic [N*W-1:0] re, input logic [N*W-1:0] im);
      int n = 0;
      bit acc = 0;
      in_valid = 1; din_real = re; din_imag = im;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready && !rst;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL send_timeout got=0 want=1");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout got=%0d want=0", q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] ramp(input int base, input bit neg);
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = neg ? W'(-(base + k)) : W'(base + k);
      return v;
   endfunction

   function automatic logic [N*W-1:0] rnd();
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
      return v;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      // idle after reset
      repeat (50) @(posedge clk);
      #1;

      // single symbol, free-running output
      send(ramp(0, 0), ramp(0, 1));
      in_valid = 0;
      drain();

      // stall during output cycles 3-5
      send(ramp(0, 0), ramp(0, 1));
      in_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 0;
      @(negedge clk);
      chk("stall_re", dout_real, 14);
      chk("stall_idx", idx, 2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1;
      drain();

      // back-to-back symbols
      send(ramp(0, 0), ramp(0, 1));
      send(ramp(100, 0), ramp(100, 1));
      in_valid = 0;
      drain();

      // new symbol offered mid-SEND must wait for eof
      send(ramp(0, 0), ramp(0, 1));
      in_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      send(ramp(200, 0), ramp(200, 1));
      in_valid = 0;
      drain();

      // reset while idx = 7
      send(ramp(0, 0), ramp(0, 1));
      in_valid = 0;
      begin
         int n = 0;
         while (idx != 7 && n < 100) begin
            @(posedge clk); #1; n++;
         end
      end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_idx", idx, 0);
      @(posedge clk); #1;
      send(ramp(50, 0), ramp(50, 1));
      in_valid = 0;
      drain();

      // random traffic with occasional reset
      repeat (3000) begin
         in_valid  = ($urandom_range(0, 2) == 0);
         din_real  = rnd();
         din_imag  = rnd();
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      rst = 0; in_valid = 0; out_ready = 1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/p_s_cp_insert.md
P_S_CP_INSERT -- requirements
Module: p_s_cp_insert

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each real and imag sample component, signed two's complement.
REQ-002 Parameter N, default 16: FFT/IFFT size, i.e. data samples per OFDM symbol.
REQ-003 Parameter CP, default 4: cyclic prefix length in samples; 0 < CP < N.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  parallel symbol present on din_real/din_imag.
REQ-007 in_ready  output  1  block accepts a symbol this cycle.
REQ-008 din_real  input  N*WIDTH  packed real parts; sample k at bits [k*WIDTH +: WIDTH].
REQ-009 din_imag  input  N*WIDTH  packed imag parts; same packing as din_real.
REQ-010 out_valid  output  1  dout_real/dout_imag hold a valid serial sample.
REQ-011 out_ready  input  1  downstream accepts the sample this cycle.
REQ-012 dout_real  output  WIDTH  serial real sample.
REQ-013 dout_imag  output  WIDTH  serial imag sample.
REQ-014 sof  output  1  high with the first sample of a symbol (first CP sample).
REQ-015 eof  output  1  high with the last sample of a symbol.
REQ-016 idx  output  $clog2(N+CP)  position of the current output sample within the symbol, 0..N+CP-1.

Function
REQ-017 The block SHALL use two states: IDLE (no symbol buffered) and SEND (symbol buffered, serializing).
REQ-018 Input transfer SHALL occur on a rising edge with in_valid && in_ready; all N complex samples are captured into an internal symbol buffer.
REQ-019 in_ready SHALL be 1 in IDLE, and in SEND only when out_valid && out_ready && idx == N+CP-1 (combinational path from out_ready permitted).
REQ-020 On an input transfer the state SHALL become SEND and idx SHALL become 0; out_valid is high the cycle after the transfer (latency 1).
REQ-021 out_valid SHALL equal (state == SEND).
REQ-022 Output transfer SHALL occur on a rising edge with out_valid && out_ready; idx then increments by 1.
REQ-023 For idx < CP the output SHALL be buffer sample N-CP+idx; for idx >= CP it SHALL be buffer sample idx-CP.
REQ-024 sof SHALL equal out_valid && idx == 0; eof SHALL equal out_valid && idx == N+CP-1.
REQ-025 While out_valid && !out_ready, dout_real, dout_imag, idx, sof and eof SHALL hold unchanged.
REQ-026 On the transfer at idx == N+CP-1 with no simultaneous input transfer, the state SHALL return to IDLE and idx to 0.
REQ-027 On the transfer at idx == N+CP-1 with a simultaneous input transfer, the new symbol SHALL be loaded, the state SHALL remain SEND, and idx SHALL wrap to 0 with no bubble cycle.
REQ-028 With out_ready held 1 and symbols always available, sustained throughput SHALL be one symbol per N+CP cycles.
REQ-029 in_valid while in_ready == 0 SHALL be ignored; the buffered symbol SHALL NOT be modified.
REQ-030 Samples SHALL pass through bit-exact; no arithmetic, scaling or sign change.

Reset
REQ-031 While rst is high at a rising edge: state = IDLE, idx = 0, symbol buffer cleared to 0, and out_valid, sof and eof = 0; in_valid is ignored during that cycle.
REQ-032 Reset asserted mid-symbol SHALL abandon the remaining samples; after reset the next accepted symbol starts at idx 0 with sof.
REQ-033 While in IDLE, dout_real and dout_imag SHALL be 0.

Verification
REQ-034 Load one symbol with real = k, imag = -k for k = 0..15 and out_ready = 1 -> 20 consecutive outputs with real 12,13,14,15,0,1,...,15 and matching imag; sof on the 1st output, eof on the 20th; then out_valid = 0.
REQ-035 Same symbol with out_ready = 0 during output cycles 3-5 -> dout holds real = 14 and idx = 2 throughout the stall; the sequence then resumes unchanged, 20 samples total.
REQ-036 Two symbols offered back-to-back (second: real = 100+k) with out_ready = 1 -> in_ready pulses on the eof cycle, 40 contiguous valid outputs, and the 21st output is real = 112 with sof.
REQ-037 in_valid held high with a different symbol during SEND at idx = 5 -> in_ready = 0; the output sequence of the first symbol is unaffected.
REQ-038 rst pulsed for one cycle while idx = 7 -> out_valid = 0, idx = 0 the next cycle; a newly loaded symbol outputs from idx 0 with the correct CP.
REQ-039 After reset with no input -> out_valid = 0, in_ready = 1, dout = 0 for 50 cycles.
